rst_sequencer: RTL
==================

# rst_sequencer

Staged reset sequencer running on the divided system clock and the divider's synchronous active-low reset. It merges power-on reset, a debounced board reset button and a watchdog request into two ordered reset outputs. Peripherals are released first; the core follows a fixed gap later, so the core's first bus access always meets live peripherals. It also records the cause of the last reset and counts completed boots.

## Interface
- `DEBOUNCE_BITS`, default 16: button must be stable for 2^DEBOUNCE_BITS consecutive cycles to change its debounced level.
- `HOLD_CYCLES`, default 16: cycles both resets stay asserted in HOLD; legal range ≥1.
- `STAGE_GAP`, default 8: cycles between peripheral release and core release; legal range ≥1.
- `clk` in 1: system clock; all logic on its rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `btn_rst` in 1: raw board button, asynchronous, active-high.
- `wdt_rst` in 1: synchronous, active-high watchdog reset request; single-cycle or level.
- `periph_resetn` out 1: active-low reset for peripherals; registered.
- `core_resetn` out 1: active-low reset for the core; registered.
- `rst_active` out 1: high whenever `core_resetn` is low.
- `rst_cause` out 2: cause of the last reset. 00 = power-on, 01 = button, 10 = watchdog, 11 = reserved and never driven.
- `boot_count` out 8: number of entries into RUN since `resetn`; saturates at 255.

## Operation
- **Button path.**
  - Two-flop synchronizer feeds the debouncer.
  - The debounce counter (DEBOUNCE_BITS wide) clears whenever the synchronized value differs from the debounced level.
  - When the counter reaches all-ones, the debounced level flips and the counter clears.
  - A press is a 0→1 edge of the debounced level.
- **FSM states:** HOLD, PERIPH_UP, RUN. A shared stage counter is cleared on every state entry.
  - **HOLD:** both resets low. The counter advances only while the debounced button level is low. At count HOLD_CYCLES-1 → PERIPH_UP.
  - **PERIPH_UP:** `periph_resetn`=1, `core_resetn`=0. At count STAGE_GAP-1 → RUN.
  - **RUN:** both resets high.
    - A press → HOLD with cause 01.
    - Otherwise, `wdt_rst` high → HOLD with cause 10.
    - Button wins when both occur in the same cycle.
- **Requests outside RUN.**
  - A press during HOLD or PERIPH_UP → HOLD, counter cleared, cause set to 01.
  - `wdt_rst` is ignored outside RUN.
- **`boot_count`:** increments on each PERIPH_UP→RUN transition; holds at 255.
- **`resetn` low, in any state:**
  - state = HOLD, all counters cleared;
  - synchronizer flops and debounced level = 0;
  - `periph_resetn`=0, `core_resetn`=0, `rst_active`=1, `rst_cause`=00, `boot_count`=0.
- **Counter width:** enough bits to hold max(HOLD_CYCLES, STAGE_GAP) with no wrap.

## Timing
- Edge 0 is the first rising edge at which `resetn` is sampled high.
- `periph_resetn` rises on edge HOLD_CYCLES, provided the button is idle.
- `core_resetn` and `rst_active` change on edge HOLD_CYCLES+STAGE_GAP. `boot_count` increments on the same edge.
- Button press latency, from the raw rising edge to both resets low: 2 synchronizer cycles + 2^DEBOUNCE_BITS stable cycles + 1 FSM cycle.
- Watchdog latency: `wdt_rst` sampled high in RUN drives both resets low on the next edge. `rst_cause` updates on that same edge.
- A held button keeps the FSM in HOLD indefinitely. Release begins after the debounced level falls, then HOLD_CYCLES further cycles.
- Glitches shorter than 2^DEBOUNCE_BITS cycles produce no reset.
- Outputs never glitch; all are flop outputs.

## Configuration
- Macro: `RST_SEQ_WDT_EN`.
- **Defined:** the watchdog path behaves as specified above.
- **Undefined:**
  - the `wdt_rst` port remains but is ignored;
  - the watchdog transition logic is not built;
  - `rst_cause` never takes value 10.

## Test plan
Bench parameters: DEBOUNCE_BITS=3, HOLD_CYCLES=4, STAGE_GAP=2.

- **Power-on:** release `resetn` → `periph_resetn` rises on edge 4; `core_resetn` rises on edge 6; `boot_count`=1; `rst_cause`=00.
- **Button press in RUN:** hold `btn_rst` 20 cycles, then release → resets low 11 cycles after the press. They stay low while the button is held. After the debounced fall, `periph_resetn` rises 4 cycles later and `core_resetn` 6 cycles later. `rst_cause`=01, `boot_count`=2.
- **Glitch rejection:** `btn_rst` pulses of 1–7 cycles in RUN → no reset; `boot_count` unchanged.
- **Watchdog:** 1-cycle `wdt_rst` in RUN → both resets low on the next edge; `rst_cause`=10; re-release after 4/6 cycles.
- **Collisions:**
  - debounced press and `wdt_rst` in the same RUN cycle → `rst_cause`=01;
  - `wdt_rst` during PERIPH_UP → ignored; `core_resetn` still rises on schedule.
- **Mid-sequence reset:** assert `resetn` during PERIPH_UP → next edge gives all outputs at reset values, including `boot_count`=0. Rebuild with `RST_SEQ_WDT_EN` undefined → `wdt_rst` never causes a reset.

Source files
------------

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: merges power-on, debounced button and watchdog requests
// into ordered peripheral/core resets. Watchdog path is built only with RST_SEQ_WDT_EN.
module rst_sequencer #(
    parameter int DEBOUNCE_BITS = 16,
    parameter int HOLD_CYCLES   = 16,
    parameter int STAGE_GAP     = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       btn_rst,
    input  logic       wdt_rst,
    output logic       periph_resetn,
    output logic       core_resetn,
    output logic       rst_active,
    output logic [1:0] rst_cause,
    output logic [7:0] boot_count
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [1:0] CAUSE_BTN = 2'b01;
`ifdef RST_SEQ_WDT_EN
    localparam logic [1:0] CAUSE_WDT = 2'b10;
`else
    logic unused_wdt;
    assign unused_wdt = wdt_rst;
`endif

    typedef enum logic [1:0] {HOLD, PERIPH_UP, RUN} state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic [1:0]               cause_nxt;
    logic                     boot_inc;
    logic                     armed;
    logic                     btn_meta, btn_sync, btn_level, btn_level_d;
    logic [DEBOUNCE_BITS-1:0] db_cnt;
    logic                     press;

    // The debounce counter only runs while the synchronized input disagrees with the level.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            btn_meta    <= 1'b0;
            btn_sync    <= 1'b0;
            btn_level   <= 1'b0;
            btn_level_d <= 1'b0;
            db_cnt      <= '0;
        end else begin
            btn_meta    <= btn_rst;
            btn_sync    <= btn_meta;
            btn_level_d <= btn_level;
            if (btn_sync == btn_level) begin
                db_cnt <= '0;
            end else if (db_cnt == '1) begin
                btn_level <= btn_sync;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press = btn_level & ~btn_level_d;

    // The first edge out of reset is the entry into HOLD, so the count starts one edge later.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cause_nxt = rst_cause;
        boot_inc  = 1'b0;
        unique case (state)
            HOLD: begin
                if (press) begin
                    cnt_nxt   = '0;
                    cause_nxt = CAUSE_BTN;
                end else if (!btn_level && armed) begin
                    if (cnt == HOLD_LAST) begin
                        state_nxt = PERIPH_UP;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            PERIPH_UP: begin
                if (press) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                    cause_nxt = CAUSE_BTN;
                end else if (cnt == GAP_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    boot_inc  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RUN: begin
                if (press) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                    cause_nxt = CAUSE_BTN;
                end
`ifdef RST_SEQ_WDT_EN
                else if (wdt_rst) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                    cause_nxt = CAUSE_WDT;
                end
`endif
            end
            default: begin
                state_nxt = HOLD;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= HOLD;
            cnt           <= '0;
            armed         <= 1'b0;
            rst_cause     <= 2'b00;
            boot_count    <= 8'd0;
            periph_resetn <= 1'b0;
            core_resetn   <= 1'b0;
            rst_active    <= 1'b1;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            armed         <= 1'b1;
            rst_cause     <= cause_nxt;
            periph_resetn <= (state_nxt != HOLD);
            core_resetn   <= (state_nxt == RUN);
            rst_active    <= (state_nxt != RUN);
            if (boot_inc && boot_count != 8'hFF) begin
                boot_count <= boot_count + 8'd1;
            end
        end
    end

endmodule
